// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer
// Flow-controlled nested-loop source for the convolution MAC datapath.
// The loop order is out_row > out_col > k_row > k_col, with k_col innermost.
// One beat is emitted per valid/ready handshake and carries:
//   - the output pixel position,
//   - the kernel tap,
//   - the flat input pixel address.
// Every output is registered. The next-state logic computes the next index
// set, and the flags and the address are all derived from that same set, so
// they always line up with the indices they describe.
`timescale 1ns/1ps

module conv_window_sequencer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 5,
  localparam int OUT_W = IMG_W - K + 1,
  localparam int OUT_H = IMG_H - K + 1,
  localparam int RW    = $clog2(IMG_H),
  localparam int CW    = $clog2(IMG_W),
  localparam int KW    = $clog2(K),
  localparam int AW    = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          clr,
  input  logic          ready,
  output logic          valid,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic [KW-1:0] k_row,
  output logic [KW-1:0] k_col,
  output logic [AW-1:0] pix_addr,
  output logic          first,
  output logic          last,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [KW-1:0] K_MAX   = KW'(K - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(OUT_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(OUT_H - 1);

  logic [1:0]    state_reg, state_next;
  logic [RW-1:0] row_reg, row_next;
  logic [CW-1:0] col_reg, col_next;
  logic [KW-1:0] krow_reg, krow_next;
  logic [KW-1:0] kcol_reg, kcol_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic          valid_reg, valid_next;
  logic          first_reg, first_next;
  logic          last_reg, last_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;

  // The address is widened by one bit so that the row*IMG_W + col sum
  // cannot wrap before it is truncated back to AW bits.
  logic [AW:0]   row_sum, col_sum, addr_wide;

  // Next-state logic: advance the loop nest on a handshake.
  // clr overrides everything else.
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    krow_next  = krow_reg;
    kcol_next  = kcol_reg;

    case (state_reg)
      S_IDLE: begin
        row_next  = '0;
        col_next  = '0;
        krow_next = '0;
        kcol_next = '0;
        if (start) state_next = S_RUN;
      end

      S_RUN: begin
        if (ready) begin
          if (kcol_reg != K_MAX) begin
            kcol_next = kcol_reg + 1'b1;
          end else begin
            kcol_next = '0;
            if (krow_reg != K_MAX) begin
              krow_next = krow_reg + 1'b1;
            end else begin
              krow_next = '0;
              if (col_reg != COL_MAX) begin
                col_next = col_reg + 1'b1;
              end else begin
                col_next = '0;
                if (row_reg != ROW_MAX) begin
                  row_next = row_reg + 1'b1;
                end else begin
                  // Final beat accepted: every index has wrapped back to 0.
                  row_next   = '0;
                  state_next = S_DONE;
                end
              end
            end
          end
        end
      end

      S_DONE: begin
        // A start that arrives while DONE is dropped deliberately.
        // A new scan can only begin from IDLE.
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase

    if (clr) begin
      state_next = S_IDLE;
      row_next   = '0;
      col_next   = '0;
      krow_next  = '0;
      kcol_next  = '0;
    end
  end

  // Derive the flags and the address from the next index set.
  // Outside RUN the indices are zero, so the address is zero as well.
  always_comb begin
    valid_next = (state_next == S_RUN);
    busy_next  = (state_next != S_IDLE);
    done_next  = (state_next == S_DONE);
    first_next = valid_next && (krow_next == '0) && (kcol_next == '0);
    last_next  = valid_next && (krow_next == K_MAX) && (kcol_next == K_MAX);
    row_sum    = (AW+1)'(row_next) + (AW+1)'(krow_next);
    col_sum    = (AW+1)'(col_next) + (AW+1)'(kcol_next);
    addr_wide  = row_sum * (AW+1)'(IMG_W) + col_sum;
    addr_next  = addr_wide[AW-1:0];
  end

  // State and output registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      krow_reg  <= '0;
      kcol_reg  <= '0;
      addr_reg  <= '0;
      valid_reg <= 1'b0;
      first_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      krow_reg  <= krow_next;
      kcol_reg  <= kcol_next;
      addr_reg  <= addr_next;
      valid_reg <= valid_next;
      first_reg <= first_next;
      last_reg  <= last_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign valid    = valid_reg;
  assign out_row  = row_reg;
  assign out_col  = col_reg;
  assign k_row    = krow_reg;
  assign k_col    = kcol_reg;
  assign pix_addr = addr_reg;
  assign first    = first_reg;
  assign last     = last_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule
